// File: rtl/pc_pkg.sv
// Shared definitions for the program-sequencing unit: mode width and
// sequencing-operation encodings supplied by the control unit.
package pc_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_INC  = 3'b000;
  localparam logic [MODE_W-1:0] MODE_JMP  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_JZ   = 3'b010;
  localparam logic [MODE_W-1:0] MODE_JNZ  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_CALL = 3'b100;
  localparam logic [MODE_W-1:0] MODE_RET  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b110;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: LIFO of AW-bit entries with a registered depth
// counter and a combinational read of the top entry.
module pc_ras #(
  parameter int AW    = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            din,
  output logic [AW-1:0]            top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full
);

  localparam int IW = $clog2(DEPTH);
  localparam int DW = IW + 1;

  logic [AW-1:0] mem_q [DEPTH];
  logic [DW-1:0] depth_q;
  logic [DW-1:0] depth_d;
  logic [IW-1:0] top_idx_s;
  logic          empty_s;
  logic          full_s;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty_s   = (depth_q == {DW{1'b0}});
  assign full_s    = (depth_q == DW'(DEPTH));
  assign do_push_s = push && !full_s;
  assign do_pop_s  = pop && !empty_s;
  assign top_idx_s = depth_q[IW-1:0] - IW'(1);

  always_comb begin
    depth_d = depth_q;
    if (do_push_s) begin
      depth_d = depth_q + DW'(1);
    end else if (do_pop_s) begin
      depth_d = depth_q - DW'(1);
    end else begin
      depth_d = depth_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= {DW{1'b0}};
    end else begin
      depth_q <= depth_d;
    end
  end

  // Entry storage carries no reset; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[depth_q[IW-1:0]] <= din;
    end
  end

  assign top   = empty_s ? {AW{1'b0}} : mem_q[top_idx_s];
  assign depth = depth_q;
  assign empty = empty_s;
  assign full  = full_s;

endmodule

// File: rtl/pc_seq.sv
// Program-sequencing unit: registered PC with jumps, zero-conditional
// branches, call/return through the RAS and sticky stack-error flags.
module pc_seq
  import pc_pkg::*;
#(
  parameter int            AW           = 10,
  parameter int            DEPTH        = 8,
  parameter logic [AW-1:0] RESET_VECTOR = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [MODE_W-1:0]        mode,
  input  logic [AW-1:0]            target,
  input  logic                     zero,
  output logic [AW-1:0]            pc,
  output logic [AW-1:0]            ras_top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic          ovf_q;
  logic          ovf_d;
  logic          unf_q;
  logic          unf_d;
  logic [AW-1:0] pc_inc_s;
  logic          push_s;
  logic          pop_s;
  logic [AW-1:0] ras_top_s;
  logic          ras_empty_s;
  logic          ras_full_s;

  // Wraps modulo 2^AW; also the return address pushed by CALL.
  assign pc_inc_s = pc_q + AW'(1);

  always_comb begin
    pc_d   = pc_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (en) begin
      case (mode)
        MODE_INC:  pc_d = pc_inc_s;
        MODE_JMP:  pc_d = target;
        MODE_JZ:   pc_d = zero ? target : pc_inc_s;
        MODE_JNZ:  pc_d = zero ? pc_inc_s : target;
        MODE_CALL: begin
          if (ras_full_s) begin
            pc_d  = pc_inc_s;
            ovf_d = 1'b1;
          end else begin
            pc_d   = target;
            push_s = 1'b1;
          end
        end
        MODE_RET: begin
          if (ras_empty_s) begin
            pc_d  = pc_inc_s;
            unf_d = 1'b1;
          end else begin
            pc_d  = ras_top_s;
            pop_s = 1'b1;
          end
        end
        MODE_HOLD: pc_d = pc_q;
        default:   pc_d = pc_q;
      endcase
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  pc_ras #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (pc_inc_s),
    .top   (ras_top_s),
    .depth (depth),
    .empty (ras_empty_s),
    .full  (ras_full_s)
  );

  assign pc      = pc_q;
  assign ras_top = ras_top_s;
  assign empty   = ras_empty_s;
  assign full    = ras_full_s;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios plus random stimulus
// compared against a queue-based reference model of the sequencer.
module tb_pc_seq;

  localparam int AW    = 10;
  localparam int DEPTH = 8;
  localparam int DW    = 4;
  localparam int MOD   = 1 << AW;

  localparam int INC = 0, JMP = 1, JZ = 2, JNZ = 3, CALL = 4, RET = 5, HOLD = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [2:0]    mode;
  logic [AW-1:0] target;
  logic          zero;
  logic [AW-1:0] pc;
  logic [AW-1:0] ras_top;
  logic [DW-1:0] depth;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          unf;

  int n_cmp = 0;
  int n_bad = 0;

  int m_pc;
  int m_stk[$];
  bit m_ovf;
  bit m_unf;

  pc_seq #(.AW(AW), .DEPTH(DEPTH), .RESET_VECTOR(10'd0)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .target  (target),
    .zero    (zero),
    .pc      (pc),
    .ras_top (ras_top),
    .depth   (depth),
    .empty   (empty),
    .full    (full),
    .ovf     (ovf),
    .unf     (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input bit e, input int md, input int tg, input bit z);
    int nxt;
    if (!e) return;
    nxt = (m_pc + 1) % MOD;
    case (md)
      INC:  m_pc = nxt;
      JMP:  m_pc = tg;
      JZ:   m_pc = z ? tg : nxt;
      JNZ:  m_pc = z ? nxt : tg;
      CALL: begin
        if (m_stk.size() == DEPTH) begin
          m_ovf = 1'b1;
          m_pc  = nxt;
        end else begin
          m_stk.push_back(nxt);
          m_pc = tg;
        end
      end
      RET: begin
        if (m_stk.size() == 0) begin
          m_unf = 1'b1;
          m_pc  = nxt;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end
      default: m_pc = m_pc;
    endcase
  endtask

  task automatic check_all(input string tag);
    int top;
    top = (m_stk.size() == 0) ? 0 : m_stk[$];
    chk({tag, ".pc"},      pc,      m_pc);
    chk({tag, ".ras_top"}, ras_top, top);
    chk({tag, ".depth"},   depth,   m_stk.size());
    chk({tag, ".empty"},   empty,   int'(m_stk.size() == 0));
    chk({tag, ".full"},    full,    int'(m_stk.size() == DEPTH));
    chk({tag, ".ovf"},     ovf,     int'(m_ovf));
    chk({tag, ".unf"},     unf,     int'(m_unf));
  endtask

  task automatic step(input string tag, input bit e, input int md, input int tg, input bit z);
    en     = e;
    mode   = md[2:0];
    target = tg[AW-1:0];
    zero   = z;
    @(posedge clk);
    model_step(e, md, tg, z);
    #1;
    check_all(tag);
  endtask

  initial begin
    int p;
    int q;
    reset  = 1'b1;
    en     = 1'b0;
    mode   = 3'd0;
    target = '0;
    zero   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step("inc", 1'b1, INC, 0, 1'b0);
      chk("inc.seq", pc, i + 1);
    end

    step("jmp_top", 1'b1, JMP, 1023, 1'b0);
    step("wrap", 1'b1, INC, 0, 1'b0);
    chk("wrap.zero", pc, 0);
    step("en_off", 1'b0, JMP, 5, 1'b0);
    step("en_off", 1'b0, JMP, 5, 1'b0);
    chk("en_off.hold", pc, 0);

    step("jmp10", 1'b1, JMP, 10, 1'b0);
    step("jz_nt", 1'b1, JZ, 200, 1'b0);
    chk("jz_nt.pc", pc, 11);
    step("jz_t", 1'b1, JZ, 200, 1'b1);
    chk("jz_t.pc", pc, 200);
    step("jnz_nt", 1'b1, JNZ, 50, 1'b1);
    chk("jnz_nt.pc", pc, 201);
    step("jnz_t", 1'b1, JNZ, 50, 1'b0);

    step("jmp20", 1'b1, JMP, 20, 1'b0);
    step("call1", 1'b1, CALL, 100, 1'b0);
    chk("call1.top", ras_top, 21);
    step("call2", 1'b1, CALL, 300, 1'b0);
    chk("call2.top", ras_top, 101);
    step("ret1", 1'b1, RET, 0, 1'b0);
    chk("ret1.pc", pc, 101);
    step("ret2", 1'b1, RET, 0, 1'b0);
    chk("ret2.pc", pc, 21);
    chk("ret2.empty", empty, 1);

    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, CALL, 500 + 10 * i, 1'b0);
    chk("fill.full", full, 1);
    p = m_pc;
    step("ovf", 1'b1, CALL, 400, 1'b0);
    chk("ovf.pc", pc, (p + 1) % MOD);
    chk("ovf.flag", ovf, 1);
    step("ovf_hold", 1'b1, HOLD, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b1, RET, 0, 1'b0);
    q = m_pc;
    step("unf", 1'b1, RET, 0, 1'b0);
    chk("unf.pc", pc, (q + 1) % MOD);
    chk("unf.flag", unf, 1);
    chk("unf.ovf_sticky", ovf, 1);
    step("rsvd", 1'b1, 7, 77, 1'b1);

    for (int i = 0; i < 3; i++) step("stack3", 1'b1, CALL, 600 + i, 1'b0);
    chk("stack3.depth", depth, 3);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    reset = 1'b0;

    for (int i = 0; i < 600; i++) begin
      int md;
      md = (i < 300 && $urandom_range(0, 3) == 0) ? CALL : int'($urandom_range(0, 7));
      step("rand", $urandom_range(0, 9) != 0, md, int'($urandom_range(0, MOD - 1)),
           bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
